// File: rtl/logicnet_layer_sequencer.sv
// logicnet_layer_sequencer: time-multiplexed LogicNet layer, one shared LUT memory evaluated neuron by neuron
module logicnet_layer_sequencer #(
  parameter int NUM_IN_CH   = 8,
  parameter int NUM_NEURONS = 16,
  parameter int CH_BITS     = 2,
  parameter int FANIN       = 3,
  parameter int CFG_AW      = 10
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           cfg_we,
  input  logic                           cfg_sel,
  input  logic [CFG_AW-1:0]              cfg_addr,
  input  logic [7:0]                     cfg_wdata,
  output logic                           cfg_err,
  input  logic                           in_valid,
  output logic                           in_ready,
  input  logic [NUM_IN_CH*CH_BITS-1:0]   in_data,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic [NUM_NEURONS*CH_BITS-1:0] out_data,
  output logic                           busy
);
  localparam int A   = FANIN*CH_BITS;
  localparam int NW  = $clog2(NUM_NEURONS);
  localparam int CW  = $clog2(NUM_IN_CH);
  localparam int LW  = NW+A;
  localparam int CD  = NUM_NEURONS*FANIN;
  localparam int CIW = $clog2(CD);
  typedef enum logic [1:0] {IDLE, GATHER, READ, DONE} state_t;
  state_t state;
  logic [CH_BITS-1:0] lut [2**LW];
  logic [CW-1:0] conn [CD];
  logic [NUM_IN_CH*CH_BITS-1:0] sample;
  logic [NW-1:0] n;
  logic [LW-1:0] rd_addr;
  logic [A-1:0] addr;
  logic [CIW-1:0] ci;
  logic [CW-1:0] cs;
  logic cfg_ok;
  logic unused_cfg;
  assign in_ready = state == IDLE;
  assign busy = state == GATHER || state == READ;
  assign cfg_ok = cfg_we && (state == IDLE || state == DONE);
  assign unused_cfg = ^cfg_wdata;
  // fan-in 0 lands in the LSBs; an out-of-range channel index contributes zero
  always_comb begin
    addr = '0;
    ci = '0;
    cs = '0;
    for (int k = 0; k < FANIN; k++) begin
      ci = CIW'(int'(n)*FANIN + k);
      cs = conn[ci];
      addr[k*CH_BITS +: CH_BITS] = (int'(cs) < NUM_IN_CH) ? sample[int'(cs)*CH_BITS +: CH_BITS] : '0;
    end
  end
  always_ff @(posedge clk) begin
    if (cfg_ok && !cfg_sel && (cfg_addr >> LW) == '0)
      lut[LW'(cfg_addr)] <= cfg_wdata[CH_BITS-1:0];
    if (cfg_ok && cfg_sel && int'(cfg_addr) < CD)
      conn[CIW'(cfg_addr)] <= cfg_wdata[CW-1:0];
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      n         <= '0;
      sample    <= '0;
      rd_addr   <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      cfg_err   <= 1'b0;
    end else begin
      cfg_err <= cfg_we && (state == GATHER || state == READ);
      case (state)
        IDLE: if (in_valid) begin
          sample <= in_data;
          n      <= '0;
          state  <= GATHER;
        end
        GATHER: begin
          rd_addr <= {n, addr};
          state   <= READ;
        end
        READ: begin
          out_data[int'(n)*CH_BITS +: CH_BITS] <= lut[rd_addr];
          if (n == NW'(NUM_NEURONS-1)) begin
            out_valid <= 1'b1;
            state     <= DONE;
          end else begin
            n     <= n + 1'b1;
            state <= GATHER;
          end
        end
        DONE: if (out_ready) begin
          out_valid <= 1'b0;
          state     <= IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_logicnet_layer_sequencer.sv
// tb_logicnet_layer_sequencer: directed and random checks against a table-lookup reference model
module tb_logicnet_layer_sequencer;
  logic clk = 0, rst = 1, cfg_we = 0, cfg_sel = 0, cfg_err;
  logic in_valid = 0, in_ready, out_valid, out_ready = 0, busy;
  logic [9:0] cfg_addr = '0;
  logic [7:0] cfg_wdata = '0;
  logic [15:0] in_data = '0;
  logic [31:0] out_data;
  int lut_m [1024];
  int conn_m [48];
  int n_cmp = 0, n_bad = 0, cyc = 0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  logicnet_layer_sequencer dut (
    .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_sel(cfg_sel), .cfg_addr(cfg_addr),
    .cfg_wdata(cfg_wdata), .cfg_err(cfg_err), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .busy(busy)
  );
  function automatic logic [31:0] model(input logic [15:0] d);
    logic [31:0] r = '0;
    for (int j = 0; j < 16; j++) begin
      int a = 0;
      for (int k = 0; k < 3; k++) begin
        int c = conn_m[j*3+k];
        int v = (c < 8) ? ((int'(d) >> (2*c)) & 3) : 0;
        a += v << (2*k);
      end
      r[j*2 +: 2] = 2'(lut_m[j*64+a]);
    end
    return r;
  endfunction
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic cfg(input bit sel, input int a, input int v);
    cfg_we = 1; cfg_sel = sel; cfg_addr = 10'(a); cfg_wdata = 8'(v);
    @(negedge clk);
    cfg_we = 0;
    if (sel) conn_m[a] = v; else lut_m[a] = v;
  endtask
  task automatic send(input logic [15:0] d);
    in_valid = 1; in_data = d;
    @(negedge clk);
    in_valid = 0;
  endtask
  task automatic wait_valid(output int cnt);
    cnt = 0;
    while (!out_valid && cnt < 100) begin
      @(negedge clk);
      cnt++;
    end
  endtask
  task automatic drain();
    out_ready = 1;
    @(negedge clk);
    out_ready = 0;
  endtask
  task automatic run(input string tag, input logic [15:0] d);
    int cnt;
    send(d);
    wait_valid(cnt);
    chk({tag, "_lat"}, cnt, 32);
    chk({tag, "_data"}, out_data, model(d));
    drain();
    chk({tag, "_drained"}, out_valid, 0);
  endtask
  initial begin
    int cnt, t, tprev;
    logic [15:0] d, db;
    logic [31:0] e1;
    #1;
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_cfg_err", cfg_err, 0);
    chk("rst_busy", busy, 0);
    @(negedge clk);
    rst = 0;
    for (int i = 0; i < 1024; i++) cfg(0, i, $urandom_range(3));
    for (int i = 0; i < 48; i++) cfg(1, i, $urandom_range(7));
    // basic: neuron 0 sees channels 0,1,2 -> address 57
    cfg(1, 0, 0); cfg(1, 1, 1); cfg(1, 2, 2);
    for (int e = 0; e < 64; e++) cfg(0, e, (e == 57) ? 1 : 3);
    db = {10'($urandom), 6'b111001};
    send(db);
    chk("basic_busy", busy, 1);
    wait_valid(cnt);
    chk("basic_lat", cnt, 32);
    chk("basic_n0", out_data[1:0], 2'b01);
    chk("basic_data", out_data, model(db));
    chk("basic_in_ready", in_ready, 0);
    drain();
    chk("basic_idle", in_ready, 1);
    // full layer, back-to-back with out_ready held high
    in_valid = 1; out_ready = 1; tprev = 0;
    for (int s = 0; s < 20; s++) begin
      cnt = 0;
      while (!in_ready && cnt < 200) begin @(negedge clk); cnt++; end
      d = 16'($urandom);
      in_data = d;
      t = cyc;
      if (s > 0) chk("full_thru", t - tprev, 34);
      tprev = t;
      @(negedge clk);
      wait_valid(cnt);
      chk("full_lat", cnt, 32);
      chk("full_data", out_data, model(d));
      @(negedge clk);
    end
    in_valid = 0; out_ready = 0;
    // backpressure
    d = 16'($urandom);
    send(d);
    wait_valid(cnt);
    e1 = model(d);
    chk("bp_lat", cnt, 32);
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      chk("bp_stable", out_data, e1);
      chk("bp_in_ready", in_ready, 0);
      chk("bp_valid", out_valid, 1);
      in_valid = (i == 10 || i == 11);
      in_data = 16'($urandom);
    end
    in_valid = 0;
    cfg(1, 10, $urandom_range(7));
    chk("bp_cfg_ok", cfg_err, 0);
    chk("bp_held", out_data, e1);
    drain();
    chk("bp_drained", out_valid, 0);
    run("bp_next", 16'($urandom));
    // write rejected during READ of neuron 5
    d = 16'($urandom);
    send(d);
    repeat (11) @(negedge clk);
    chk("rej_busy", busy, 1);
    cfg_we = 1; cfg_sel = 0; cfg_addr = 10'd57; cfg_wdata = 8'(lut_m[57] ^ 3);
    @(negedge clk);
    cfg_we = 0;
    chk("rej_err", cfg_err, 1);
    @(negedge clk);
    chk("rej_err_clr", cfg_err, 0);
    wait_valid(cnt);
    chk("rej_lat", cnt, 19);
    chk("rej_data", out_data, model(d));
    drain();
    send(db);
    wait_valid(cnt);
    chk("rej_rb_n0", out_data[1:0], 2'(lut_m[57]));
    chk("rej_rb_data", out_data, model(db));
    drain();
    // reset at neuron 7
    d = 16'($urandom);
    send(d);
    repeat (14) @(negedge clk);
    rst = 1;
    #1;
    chk("mrst_valid", out_valid, 0);
    chk("mrst_data", out_data, 0);
    chk("mrst_in_ready", in_ready, 1);
    @(negedge clk);
    rst = 0;
    run("mrst_next", d);
    // config write in the acceptance cycle
    cfg_we = 1; cfg_sel = 0; cfg_addr = 10'd57; cfg_wdata = 8'd2;
    in_valid = 1; in_data = db;
    lut_m[57] = 2;
    @(negedge clk);
    cfg_we = 0; in_valid = 0;
    wait_valid(cnt);
    chk("same_lat", cnt, 32);
    chk("same_n0", out_data[1:0], 2'b10);
    chk("same_data", out_data, model(db));
    drain();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/logicnet_layer_sequencer.md
Name: logicnet_layer_sequencer

Overview:
- Time-multiplexed evaluator for one LogicNet layer.
- A single shared truth-table memory holds every neuron's 2-bit-output LUT. Neurons are evaluated one at a time against a captured input vector, replacing NUM_NEURONS parallel ROM instances.
- Truth tables and per-neuron fan-in connectivity are runtime-loadable through a config write port.
- Sits between two layer register stages, with valid/ready handshakes on both sides.

Parameters:
- NUM_IN_CH, 8, number of input channels (each CH_BITS wide)
- NUM_NEURONS, 16, neurons evaluated per sample
- CH_BITS, 2, bits per input channel and per neuron output
- FANIN, 3, input channels per neuron; LUT address width A = FANIN*CH_BITS (6)
- CFG_AW, 10, config address width; must be ≥ clog2(NUM_NEURONS)+A

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- cfg_we  in  1  config write strobe
- cfg_sel  in  1  target table: 0 = LUT memory, 1 = connectivity table
- cfg_addr  in  CFG_AW  LUT: {neuron, entry}; conn: neuron*FANIN+k
- cfg_wdata  in  8  LUT: [CH_BITS-1:0] used; conn: [clog2(NUM_IN_CH)-1:0] used
- cfg_err  out  1  one-cycle pulse when a write is rejected
- in_valid  in  1  input sample valid
- in_ready  out  1  sequencer can accept a sample
- in_data  in  NUM_IN_CH*CH_BITS  channel c = in_data[c*CH_BITS +: CH_BITS]
- out_valid  out  1  layer result valid
- out_ready  in  1  downstream accepts the result
- out_data  out  NUM_NEURONS*CH_BITS  neuron n = out_data[n*CH_BITS +: CH_BITS]
- busy  out  1  high in GATHER or READ

Behaviour:
- Reset (async, rst=1):
  - state=IDLE; in_ready=1 (combinational, follows state); out_valid=0; out_data=0; neuron counter=0; cfg_err=0.
  - LUT and connectivity contents are not reset and are retained across a mid-operation reset. A mid-operation reset aborts the sample; no partial result is presented.
- States: IDLE, GATHER, READ, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid&in_ready: register in_data into a sample buffer, set n=0, go to GATHER.
- GATHER:
  - For neuron n, read conn[n*FANIN+k] for k=0..FANIN-1 and select those channels from the sample buffer.
  - Form address = {ch_sel[FANIN-1],…,ch_sel[0]}, with fan-in 0 in the LSBs.
  - Register LUT read address n*2^A+address. Go to READ.
- READ:
  - The synchronous LUT read data is written to out_data[n*CH_BITS +: CH_BITS].
  - If n==NUM_NEURONS-1, go to DONE and set out_valid=1. Otherwise n=n+1 and go to GATHER.
- DONE:
  - out_valid=1; out_data held stable; in_ready=0.
  - On out_ready: out_valid=0, go to IDLE.
  - No overlap of accept and drain.
- Latency:
  - Exactly 2*NUM_NEURONS clock edges after the acceptance edge to out_valid high (32 at defaults).
  - Throughput is one sample per 2*NUM_NEURONS+2 cycles, given immediate out_ready.
- Config writes:
  - Accepted in IDLE and DONE; take effect at the next edge.
  - A write in the same cycle as input acceptance is visible to that sample, because the first read occurs in GATHER.
  - A write during GATHER/READ is dropped and pulses cfg_err for one cycle.
  - Out-of-range addresses (conn index ≥ NUM_NEURONS*FANIN, or a stored channel index ≥ NUM_IN_CH) are not flagged. An out-of-range channel selects 0.
- out_data bits of neurons not yet evaluated keep their previous sample's values until overwritten. Only the state at out_valid=1 is specified.
- in_data changes while not accepted have no effect. The sample buffer is written only on acceptance.

Test Plan:
- Basic evaluation:
  - Stimulus: conn neuron0 = {0,1,2}; LUT[57]=2'b01; all other LUT entries of neuron 0 = 2'b11; in_data ch0=01, ch1=10, ch2=11.
  - Required: out_valid rises exactly 32 cycles after acceptance; out_data[1:0]=01.
- Full layer:
  - Stimulus: load all 16 neurons with distinct random tables/connectivity; drive 20 random samples.
  - Required: every out_data matches the reference model, with back-to-back throughput of 34 cycles/sample.
- Output backpressure:
  - Stimulus: hold out_ready=0 for 50 cycles after out_valid.
  - Required: out_data stable, in_ready=0, second in_valid ignored; drains on out_ready, then the next sample is accepted.
- Config rejection:
  - Stimulus: cfg_we to LUT[57] during READ of neuron 5.
  - Required: cfg_err pulses 1 cycle; LUT[57] unchanged on readback via the next sample.
- Reset mid-operation:
  - Stimulus: assert rst at neuron 7.
  - Required: out_valid=0, out_data=0, in_ready=1 immediately; the next sample with unchanged tables produces the correct full result.
- Same-cycle config and accept:
  - Stimulus: write LUT[57]=2'b10 in the acceptance cycle.
  - Required: out_data[1:0]=10.
